dac_load_seq: RTL

DAC_LOAD_SEQ -- requirements
Module: dac_load_seq

---
 rtl/dac_seq_pkg.sv | 21 ++
 rtl/dac_load_seq_rr_arbiter.sv | 45 ++++
 rtl/dac_load_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC load sequencer.
// Provides the sequencer state encoding, the channel address width and the
// serial frame length helper (address bits followed by the data word).
package dac_seq_pkg;

  // Channel address field width in every serial frame (eight channels).
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_e;

  // Number of serial bits per frame: address field plus data word.
  function automatic int unsigned frame_bits(input int unsigned dac_width);
    return ADDR_W + dac_width;
  endfunction

endpackage

// File: rtl/dac_load_seq_rr_arbiter.sv
// Round-robin arbiter used to pick the next channel to load.
// Ports:
//   req_i   - one request bit per channel
//   last_i  - index of the previous grant; the search starts at last_i+1
//   gnt_o   - one-hot grant (all zero when nothing is requested)
//   idx_o   - index of the granted channel
//   valid_o - high when any request is set
// Purely combinational.
module rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam int unsigned CW = IDX_W + 1;
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  // Wider than the index so last_i + k never overflows before the wrap.
  logic [CW-1:0] sum_s;
  logic [CW-1:0] cand_s;
  logic          hit_s;

  // Scan offsets 1..N from the last grant and keep the first requester found.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      sum_s   = {1'b0, last_i} + CW'(k);
      cand_s  = (sum_s >= CW'(N)) ? (sum_s - CW'(N)) : sum_s;
      hit_s   = !valid_o && req_i[cand_s[IDX_W-1:0]];
      idx_o   = hit_s ? cand_s[IDX_W-1:0] : idx_o;
      valid_o = valid_o | hit_s;
    end
    gnt_o = valid_o ? (ONE_HOT0 << idx_o) : '0;
  end

endmodule

// File: rtl/dac_load_seq.sv
// DAC load sequencer: keeps a shadow copy of every channel word last sent on
// a shared serial DAC bus and sends a frame whenever a channel word changes
// (or on force_load). Each frame is sync_n low, a setup hold, then the 3-bit
// channel address and the data word MSB first, followed by an idle gap.
// Ports:
//   clk, rst_n   - clock (rising edge) and asynchronous active-low reset
//   enable       - allows new frames to start; a running frame always completes
//   force_load   - one-cycle pulse marking every channel pending
//   dac_config   - packed channel words, channel i at [i*DAC_WIDTH +: DAC_WIDTH]
//   dac_sclk     - serial clock, idles low
//   dac_sdata    - serial data, MSB first
//   dac_sync_n   - low for the whole frame
//   busy         - high whenever the sequencer is not idle
//   active_ch    - channel of the current or most recent frame
module dac_load_seq
  import dac_seq_pkg::*;
#(
  parameter int unsigned NUM_DACS  = 8,
  parameter int unsigned DAC_WIDTH = 8,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          force_load,
  input  logic [NUM_DACS*DAC_WIDTH-1:0] dac_config,
  output logic                          dac_sclk,
  output logic                          dac_sdata,
  output logic                          dac_sync_n,
  output logic                          busy,
  output logic [ADDR_W-1:0]             active_ch
);

  localparam int unsigned FRAME_BITS = frame_bits(DAC_WIDTH);
  localparam int unsigned DIV_W      = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0]  DIV_HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_GAP_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(FRAME_BITS - 1);
  localparam logic [ADDR_W-1:0] CH_LAST       = ADDR_W'(NUM_DACS - 1);

  seq_state_e               state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic                     phase_q, phase_d;
  logic [FRAME_BITS-1:0]    frame_q, frame_d;
  logic [DAC_WIDTH-1:0]     snap_q, snap_d;
  logic [ADDR_W-1:0]        active_ch_q, active_ch_d;
  logic [NUM_DACS-1:0]      pending_q, pending_d;
  logic [DAC_WIDTH-1:0]     shadow_q [NUM_DACS];
  logic                     sclk_q, sclk_d;
  logic                     sdata_q, sdata_d;
  logic                     sync_n_q, sync_n_d;
  logic                     busy_q, busy_d;
  logic                     shadow_we_s;

  logic [DAC_WIDTH-1:0]     cfg_word_s [NUM_DACS];
  logic [DAC_WIDTH-1:0]     ref_word_s [NUM_DACS];
  logic [NUM_DACS-1:0]      cfg_diff_s;
  logic [NUM_DACS-1:0]      gnt_s;
  logic [NUM_DACS-1:0]      gnt_take_s;
  logic [ADDR_W-1:0]        gnt_idx_s;
  logic                     gnt_valid_s;
  logic                     grant_fire_s;

  rr_arbiter #(
    .N     (NUM_DACS),
    .IDX_W (ADDR_W)
  ) u_arb (
    .req_i   (pending_q),
    .last_i  (active_ch_q),
    .gnt_o   (gnt_s),
    .idx_o   (gnt_idx_s),
    .valid_o (gnt_valid_s)
  );

  assign grant_fire_s = (state_q == ST_IDLE) && enable && gnt_valid_s;
  assign gnt_take_s   = grant_fire_s ? gnt_s : '0;

  // Unpack channel words and pick what each one is compared against.
  // The channel in flight compares against its snapshot, since that is what
  // the shadow will hold once the frame finishes; a change during the frame
  // therefore re-arms pending without being masked by the stale shadow.
  always_comb begin
    for (int i = 0; i < int'(NUM_DACS); i++) begin
      cfg_word_s[i] = dac_config[i*DAC_WIDTH +: DAC_WIDTH];
      ref_word_s[i] = ((state_q != ST_IDLE) && (active_ch_q == ADDR_W'(i)))
                      ? snap_q : shadow_q[i];
      // The granted channel is being snapshotted this cycle, so it matches.
      cfg_diff_s[i] = (cfg_word_s[i] != ref_word_s[i]) && !gnt_take_s[i];
    end
  end

  // Pending update: set (change or force_load) wins over clear-on-grant.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < int'(NUM_DACS); i++) begin
      pending_d[i] = (force_load || cfg_diff_s[i]) ? 1'b1 :
                     (gnt_take_s[i] ? 1'b0 : pending_q[i]);
    end
  end

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    phase_d     = phase_q;
    frame_d     = frame_q;
    snap_d      = snap_q;
    active_ch_d = active_ch_q;
    shadow_we_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_fire_s) begin
          state_d     = ST_SETUP;
          div_d       = '0;
          bit_d       = '0;
          phase_d     = 1'b0;
          snap_d      = cfg_word_s[gnt_idx_s];
          frame_d     = {gnt_idx_s, cfg_word_s[gnt_idx_s]};
          active_ch_d = gnt_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (div_q == DIV_HALF_LAST) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // Each bit: CLK_DIV cycles with sclk low, then CLK_DIV with sclk high.
      ST_SHIFT: begin
        if (div_q == DIV_HALF_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d     = ST_GAP;
              bit_d       = '0;
              shadow_we_s = 1'b1;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (div_q == DIV_GAP_LAST) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    sync_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    sclk_d   = (state_d == ST_SHIFT) && phase_d;
    sdata_d  = sync_n_d ? 1'b0 : frame_d[FRAME_BITS-1];
    busy_d   = (state_d != ST_IDLE);
  end

  // Sequencer state, counters, frame data and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      frame_q     <= '0;
      snap_q      <= '0;
      active_ch_q <= CH_LAST;
      pending_q   <= '1;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sync_n_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      snap_q      <= snap_d;
      active_ch_q <= active_ch_d;
      pending_q   <= pending_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sync_n_q    <= sync_n_d;
      busy_q      <= busy_d;
    end
  end

  // Shadow words: written only when a frame fully completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_DACS); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we_s) begin
      shadow_q[active_ch_q] <= snap_q;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sdata  = sdata_q;
  assign dac_sync_n = sync_n_q;
  assign busy       = busy_q;
  assign active_ch  = active_ch_q;

endmodule
